// File: rtl/game_sel_pkg.sv
// Purpose: shared game-phase encoding and default idle ball position for the mode selector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_sel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_phase_t;

    // Screen-centre ball position shown while no game is running.
    localparam int DEF_RESET_X = 320;
    localparam int DEF_RESET_Y = 240;

endpackage

// File: rtl/game_mode_selector_if.sv
// Purpose: bundles mode request, per-channel controller buses and selected outputs.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level/pulse, no handshake.
//
// Signals: mode_sel, game_start (requests); ch_* packed per-channel controller state,
// channel m at [m*COORD_W +: COORD_W] / bit m; run_en, active_mode, ball_*_out,
// is_ball_moving_left, ball_send_trigger, game_over, match_over (selector outputs).
interface game_mode_selector_if #(
    parameter int NUM_MODES = 2,
    parameter int COORD_W   = 10
);
    localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

    logic [MODE_W-1:0]            mode_sel;
    logic                         game_start;
    logic [NUM_MODES*COORD_W-1:0] ch_ball_x;
    logic [NUM_MODES*COORD_W-1:0] ch_ball_y;
    logic [NUM_MODES-1:0]         ch_moving_left;
    logic [NUM_MODES-1:0]         ch_game_over;
    logic [NUM_MODES-1:0]         ch_send_trigger;

    logic [NUM_MODES-1:0]         run_en;
    logic [MODE_W-1:0]            active_mode;
    logic [COORD_W-1:0]           ball_x_out;
    logic [COORD_W-1:0]           ball_y_out;
    logic                         is_ball_moving_left;
    logic                         ball_send_trigger;
    logic                         game_over;
    logic                         match_over;

    // Driver side: switches / controllers feeding the selector.
    modport master (
        output mode_sel, game_start, ch_ball_x, ch_ball_y,
               ch_moving_left, ch_game_over, ch_send_trigger,
        input  run_en, active_mode, ball_x_out, ball_y_out,
               is_ball_moving_left, ball_send_trigger, game_over, match_over
    );

    // Selector side.
    modport slave (
        input  mode_sel, game_start, ch_ball_x, ch_ball_y,
               ch_moving_left, ch_game_over, ch_send_trigger,
        output run_en, active_mode, ball_x_out, ball_y_out,
               is_ball_moving_left, ball_send_trigger, game_over, match_over
    );

endinterface

// File: rtl/game_score_counter.sv
// Purpose: counts finished games, saturating at WIN_SCORE, and flags the match as won.
// Latency: match_over rises on the same edge that records the winning game.
// Backpressure: none; inc is a single-cycle event, ignored once saturated.
//
// Ports: clk_25MHZ, reset (sync, active-high), inc (game finished), match_over (sticky until reset).
module game_score_counter #(
    parameter int WIN_SCORE = 7
) (
    input  logic clk_25MHZ,
    input  logic reset,
    input  logic inc,
    output logic match_over
);

    localparam int SCORE_W = $clog2(WIN_SCORE + 1);
    localparam logic [SCORE_W-1:0] WIN_L = SCORE_W'(WIN_SCORE);

    logic [SCORE_W-1:0] score;

    always_ff @(posedge clk_25MHZ) begin
        if (reset) begin
            score      <= '0;
            match_over <= 1'b0;
        end else if (inc && (score != WIN_L)) begin
            score <= score + 1'b1;
            // Flag on the counting edge so the FSM sees it in its first OVER cycle.
            match_over <= ((score + 1'b1) == WIN_L);
        end
    end

endmodule

// File: rtl/game_mode_selector.sv
// Purpose: game-phase FSM choosing one of NUM_MODES controllers and muxing its ball state out.
// Latency: ball/direction/trigger outputs are registered, 1 cycle behind the selected channel.
// Backpressure: none; mode_sel is only sampled in IDLE, game_start is ignored outside IDLE.
//
// Ports: clk_25MHZ, reset (sync, active-high), bus (game_mode_selector_if.slave).
// Build option: define GAME_SCORE_EN to count games and hold in OVER once WIN_SCORE is reached;
// undefined, match_over is tied low and OVER always returns to IDLE.
module game_mode_selector
    import game_sel_pkg::*;
#(
    parameter int                   NUM_MODES   = 2,
    parameter int                   COORD_W     = 10,
    parameter logic [NUM_MODES-1:0] NET_MASK    = 2'b10,
    parameter int                   HOLD_CYCLES = 64,
    parameter int                   RESET_X     = DEF_RESET_X,
    parameter int                   RESET_Y     = DEF_RESET_Y,
    parameter int                   WIN_SCORE   = 7
) (
    input  logic                  clk_25MHZ,
    input  logic                  reset,
    game_mode_selector_if.slave   bus
);

    localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [COORD_W-1:0] RST_X     = COORD_W'(RESET_X);
    localparam logic [COORD_W-1:0] RST_Y     = COORD_W'(RESET_Y);

    game_phase_t          state;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [MODE_W-1:0]    active_q;
    logic [NUM_MODES-1:0] run_en_q;
    logic [COORD_W-1:0]   ball_x_q;
    logic [COORD_W-1:0]   ball_y_q;
    logic                 left_q;
    logic                 trig_q;
    logic                 over_q;
    logic                 match_over;

    // Out-of-range switch settings keep the previously latched mode.
    logic                 mode_ok;
    logic [MODE_W-1:0]    mode_next;
    logic [NUM_MODES-1:0] mode_onehot;
    assign mode_ok     = (int'(bus.mode_sel) < NUM_MODES);
    assign mode_next   = mode_ok ? bus.mode_sel : active_q;
    assign mode_onehot = {{(NUM_MODES-1){1'b0}}, 1'b1} << mode_next;

    // Channel mux: one indexed part-select serves any NUM_MODES.
    int                   sel_base;
    logic [COORD_W-1:0]   sel_x;
    logic [COORD_W-1:0]   sel_y;
    logic                 sel_left;
    logic                 sel_go;
    logic                 sel_trig;
    assign sel_base = int'(active_q) * COORD_W;
    assign sel_x    = bus.ch_ball_x[sel_base +: COORD_W];
    assign sel_y    = bus.ch_ball_y[sel_base +: COORD_W];
    assign sel_left = bus.ch_moving_left[active_q];
    assign sel_go   = bus.ch_game_over[active_q];
    assign sel_trig = bus.ch_send_trigger[active_q] & NET_MASK[active_q];

    always_ff @(posedge clk_25MHZ) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            active_q <= '0;
            run_en_q <= '0;
            ball_x_q <= RST_X;
            ball_y_q <= RST_Y;
            left_q   <= 1'b0;
            trig_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    active_q <= mode_next;
                    ball_x_q <= RST_X;
                    ball_y_q <= RST_Y;
                    left_q   <= 1'b0;
                    trig_q   <= 1'b0;
                    if (bus.game_start) begin
                        state    <= PLAY;
                        run_en_q <= mode_onehot;
                    end
                end
                PLAY: begin
                    // The last PLAY cycle still captures the ball, which then stays frozen in OVER.
                    ball_x_q <= sel_x;
                    ball_y_q <= sel_y;
                    left_q   <= sel_left;
                    if (sel_go) begin
                        state    <= OVER;
                        run_en_q <= '0;
                        over_q   <= 1'b1;
                        hold_cnt <= '0;
                        trig_q   <= 1'b0;
                    end else begin
                        trig_q <= sel_trig;
                    end
                end
                OVER: begin
                    trig_q <= 1'b0;
                    // Counter parks at its last value while a won match holds the FSM here.
                    if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else if (!match_over) begin
                        state    <= IDLE;
                        over_q   <= 1'b0;
                        ball_x_q <= RST_X;
                        ball_y_q <= RST_Y;
                        left_q   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef GAME_SCORE_EN
    logic score_inc;
    assign score_inc = (state == PLAY) && sel_go;

    game_score_counter #(
        .WIN_SCORE (WIN_SCORE)
    ) u_score (
        .clk_25MHZ  (clk_25MHZ),
        .reset      (reset),
        .inc        (score_inc),
        .match_over (match_over)
    );
`else
    assign match_over = 1'b0;
    logic unused_win_score;
    assign unused_win_score = (WIN_SCORE > 0);
`endif

    assign bus.run_en              = run_en_q;
    assign bus.active_mode         = active_q;
    assign bus.ball_x_out          = ball_x_q;
    assign bus.ball_y_out          = ball_y_q;
    assign bus.is_ball_moving_left = left_q;
    assign bus.ball_send_trigger   = trig_q;
    assign bus.game_over           = over_q;
    assign bus.match_over          = match_over;

endmodule

// File: tb/tb_game_mode_selector.sv
// Purpose: self-checking bench for game_mode_selector (directed table, multi-cycle sequences, random vs model).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_game_mode_selector;

    localparam int               HOLD  = 64;
    localparam int               WIN   = 2;
    localparam logic [1:0]       MASK  = 2'b10;
`ifdef GAME_SCORE_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #20 clk = ~clk;

    game_mode_selector_if #(.NUM_MODES(2), .COORD_W(10)) bus ();

    game_mode_selector #(
        .NUM_MODES   (2),
        .COORD_W     (10),
        .NET_MASK    (2'b10),
        .HOLD_CYCLES (HOLD),
        .RESET_X     (320),
        .RESET_Y     (240),
        .WIN_SCORE   (WIN)
    ) dut (
        .clk_25MHZ (clk),
        .reset     (reset),
        .bus       (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel 0 sits at (11,22) moving right, channel 1 moves left.
    task automatic drive(input logic r, input logic ms, input logic gs, input logic [9:0] x1,
                         input logic [9:0] y1, input logic [1:0] trig, input logic [1:0] gov);
        reset               = r;
        bus.mode_sel        = ms;
        bus.game_start      = gs;
        bus.ch_ball_x       = {x1, 10'd11};
        bus.ch_ball_y       = {y1, 10'd22};
        bus.ch_moving_left  = 2'b10;
        bus.ch_send_trigger = trig;
        bus.ch_game_over    = gov;
    endtask

    typedef struct {
        string      name;
        logic       rst, ms, gs;
        logic [9:0] x1, y1;
        logic [1:0] trig, gov;
        logic [1:0] e_run;
        logic       e_am;
        logic [9:0] e_x, e_y;
        logic       e_dir, e_trig, e_go;
    } vec_t;

    vec_t tbl [14];

    // Random-phase reference: phase 0 idle, 1 playing, 2 game over.
    int         m_phase, m_mode, m_left, m_wins;
    logic [9:0] m_x, m_y;
    logic       m_dir, m_trig;

    initial begin
        int n;
        int bad_run;
        logic [9:0] cx [2];
        logic [9:0] cy [2];
        logic       r, ms, gs;
        logic [1:0] ml, trig, gov;
        bit         won;

        drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 2'b00, 2'b00);

        //          name          rst ms gs  x1   y1  trg gov  run am  x    y  dir trg go
        tbl[0]  = '{"reset",      1, 0, 0, 100,  50, 0, 0,  0, 0, 320, 240, 0, 0, 0};
        tbl[1]  = '{"start_m1",   0, 1, 1, 100,  50, 0, 0,  2, 1, 320, 240, 0, 0, 0};
        tbl[2]  = '{"ball_lat",   0, 1, 0, 100,  50, 0, 0,  2, 1, 100,  50, 1, 0, 0};
        tbl[3]  = '{"trig_m1",    0, 1, 0, 101,  51, 3, 0,  2, 1, 101,  51, 1, 1, 0};
        tbl[4]  = '{"trig_off",   0, 1, 0, 102,  52, 0, 0,  2, 1, 102,  52, 1, 0, 0};
        tbl[5]  = '{"ign_gov0",   0, 0, 0, 103,  53, 0, 1,  2, 1, 103,  53, 1, 0, 0};
        tbl[6]  = '{"over",       0, 0, 0, 104,  54, 3, 2,  0, 1, 104,  54, 1, 0, 1};
        tbl[7]  = '{"over_frz",   0, 0, 1, 200, 201, 3, 0,  0, 1, 104,  54, 1, 0, 1};
        tbl[8]  = '{"rst_over",   1, 0, 0, 200, 201, 0, 0,  0, 0, 320, 240, 0, 0, 0};
        tbl[9]  = '{"start_m0",   0, 0, 1, 200, 201, 0, 0,  1, 0, 320, 240, 0, 0, 0};
        tbl[10] = '{"trig_m0",    0, 0, 0, 200, 201, 3, 0,  1, 0,  11,  22, 0, 0, 0};
        tbl[11] = '{"trig_m0b",   0, 1, 0, 200, 201, 3, 0,  1, 0,  11,  22, 0, 0, 0};
        tbl[12] = '{"rst_play",   1, 0, 0, 200, 201, 0, 0,  0, 0, 320, 240, 0, 0, 0};
        tbl[13] = '{"idle_latch", 0, 1, 0, 200, 201, 0, 0,  0, 1, 320, 240, 0, 0, 0};

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst, tbl[i].ms, tbl[i].gs, tbl[i].x1, tbl[i].y1, tbl[i].trig, tbl[i].gov);
            tick();
            chk({tbl[i].name, ".run_en"},  bus.run_en,              tbl[i].e_run);
            chk({tbl[i].name, ".mode"},    bus.active_mode,         tbl[i].e_am);
            chk({tbl[i].name, ".x"},       bus.ball_x_out,          tbl[i].e_x);
            chk({tbl[i].name, ".y"},       bus.ball_y_out,          tbl[i].e_y);
            chk({tbl[i].name, ".dir"},     bus.is_ball_moving_left, tbl[i].e_dir);
            chk({tbl[i].name, ".trig"},    bus.ball_send_trigger,   tbl[i].e_trig);
            chk({tbl[i].name, ".over"},    bus.game_over,           tbl[i].e_go);
            chk({tbl[i].name, ".match"},   bus.match_over,          1'b0);
        end

        // Game-over and start together: game-over wins, OVER lasts HOLD cycles, start ignored there.
        drive(1'b1, 1'b0, 1'b0, 10'd5, 10'd6, 2'b00, 2'b00);
        tick();
        drive(1'b0, 1'b1, 1'b1, 10'd5, 10'd6, 2'b00, 2'b00);
        tick();
        bus.game_start = 1'b0;
        tick();
        bus.ch_game_over = 2'b10;
        bus.game_start   = 1'b1;
        tick();
        chk("go_wins.over", bus.game_over, 1'b1);
        chk("go_wins.run",  bus.run_en, 2'b00);
        bus.ch_game_over = 2'b00;
        n = 0;
        bad_run = 0;
        while (bus.game_over === 1'b1 && n < 200) begin
            bus.game_start = (n < 10);
            tick();
            if (bus.run_en !== 2'b00) bad_run++;
            n++;
        end
        chk("over_len",      n, HOLD);
        chk("over_run_idle", bad_run, 0);
        chk("back_idle.x",   bus.ball_x_out, 320);
        chk("back_idle.y",   bus.ball_y_out, 240);

        // Two games in a row: with scoring the second wins the match and OVER holds until reset.
        drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 2'b00, 2'b00);
        tick();
        for (int g = 0; g < 2; g++) begin
            drive(1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 2'b00, 2'b00);
            tick();
            drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 2'b00, 2'b01);
            tick();
            bus.ch_game_over = 2'b00;
            if (g == 0) begin
                n = 0;
                while (bus.game_over === 1'b1 && n < 200) begin
                    tick();
                    n++;
                end
                chk("game1_len", n, HOLD);
            end
        end
        chk("match.set", bus.match_over, SCORE_EN);
        for (int k = 0; k < 100; k++) tick();
        chk("match.hold_over", bus.game_over, SCORE_EN);
        chk("match.sticky",    bus.match_over, SCORE_EN);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("match.rst",      bus.match_over, 1'b0);
        chk("match.rst_over", bus.game_over, 1'b0);

        // Random stimulus against the behavioural model.
        m_phase = 0; m_mode = 0; m_left = 0; m_wins = 0;
        m_x = 10'd320; m_y = 10'd240; m_dir = 1'b0; m_trig = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r    = (i == 0) || ($urandom_range(0, 199) == 0);
            ms   = 1'($urandom_range(0, 1));
            gs   = ($urandom_range(0, 3) == 0);
            ml   = 2'($urandom_range(0, 3));
            trig = 2'($urandom_range(0, 3));
            gov  = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            for (int c = 0; c < 2; c++) begin
                cx[c] = 10'($urandom);
                cy[c] = 10'($urandom);
            end
            reset               = r;
            bus.mode_sel        = ms;
            bus.game_start      = gs;
            bus.ch_ball_x       = {cx[1], cx[0]};
            bus.ch_ball_y       = {cy[1], cy[0]};
            bus.ch_moving_left  = ml;
            bus.ch_send_trigger = trig;
            bus.ch_game_over    = gov;

            won = SCORE_EN && (m_wins == WIN);
            if (r) begin
                m_phase = 0; m_mode = 0; m_wins = 0; m_left = 0;
                m_x = 10'd320; m_y = 10'd240; m_dir = 1'b0; m_trig = 1'b0;
            end else if (m_phase == 0) begin
                m_mode = int'(ms);
                m_x = 10'd320; m_y = 10'd240; m_dir = 1'b0; m_trig = 1'b0;
                if (gs) m_phase = 1;
            end else if (m_phase == 1) begin
                m_x = cx[m_mode]; m_y = cy[m_mode]; m_dir = ml[m_mode];
                if (gov[m_mode]) begin
                    m_phase = 2;
                    m_left  = HOLD;
                    m_trig  = 1'b0;
                    if (m_wins < WIN) m_wins++;
                end else begin
                    m_trig = trig[m_mode] & MASK[m_mode];
                end
            end else begin
                m_trig = 1'b0;
                if (m_left > 1) begin
                    m_left--;
                end else if (!won) begin
                    m_phase = 0;
                    m_x = 10'd320; m_y = 10'd240; m_dir = 1'b0;
                end
            end

            tick();
            chk("rnd.run_en", bus.run_en, (m_phase == 1) ? (32'd1 << m_mode) : 32'd0);
            chk("rnd.mode",   bus.active_mode, m_mode);
            chk("rnd.x",      bus.ball_x_out, m_x);
            chk("rnd.y",      bus.ball_y_out, m_y);
            chk("rnd.dir",    bus.is_ball_moving_left, m_dir);
            chk("rnd.trig",   bus.ball_send_trigger, m_trig);
            chk("rnd.over",   bus.game_over, (m_phase == 2));
            chk("rnd.match",  bus.match_over, SCORE_EN && (m_wins == WIN));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
